adc0808_scan_ctrl: RTL
======================

// Module: adc0808_scan_ctrl
// PURPOSE
//  Parametrised ADC0808 controller; replaces the single-channel, fixed-timing reader.
//  - Round-robins over a masked subset of the 8 analog inputs by driving ADD A/B/C.
//  - Programmable ALE/START/OE pulse widths.
//  - EOC timeout.
//  - Emits each sample as a one-cycle data_valid pulse tagged with its channel.
//  - Sits between the ADC0808 pins and the sample consumer (filter/FIFO).
// PARAMETERS
//  NUM_CH       8     channels scanned, 1..8; mask bits >= NUM_CH are ignored
//  ALE_CYC      2     cycles ALE/START held high, >= 1
//  EOC_GUARD    10    cycles after START falls before EOC is sampled (EOC-low latency)
//  OE_CYC       2     cycles OE held high before data_in is captured, >= 1
//  TIMEOUT_CYC  1024  max cycles in WAIT_EOC before abort
// PORTS
//  clk          in   1  system clock (also the ADC0808 conversion clock domain)
//  reset        in   1  synchronous, active-high
//  enable       in   1  1 = run continuous scan; 0 = stop after the current conversion
//  ch_mask      in   8  bit i = 1 scans channel i
//  eoc          in   1  end-of-conversion from ADC0808; treated as synchronous
//  data_in      in   8  ADC0808 data bus
//  addr         out  3  ADD C/B/A channel select
//  ale          out  1  address latch enable
//  start        out  1  start conversion
//  oe           out  1  output enable
//  data_out     out  8  captured sample; holds between captures
//  data_ch      out  3  channel of data_out
//  data_valid   out  1  one-cycle pulse: data_out/data_ch updated this cycle
//  timeout_err  out  1  one-cycle pulse: EOC timeout on channel addr
//  busy         out  1  high in every state except IDLE
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; channel pointer ptr = 0.
//  - Applies mid-operation too: the current conversion is abandoned and no valid pulse is produced.
//  FSM (one transition per clk):
//  IDLE
//  - If enable && (ch_mask & NUM_CH bits) != 0: addr <= first enabled channel >= ptr (wrap); go SETUP.
//  - If the effective mask is 0: stay IDLE; no pins toggle.
//  SETUP     1 cycle of addr setup; ale = start = 0.
//  PULSE     ale = start = 1 for exactly ALE_CYC cycles, then go GUARD.
//  GUARD     ale = start = 0; count EOC_GUARD cycles; eoc ignored; then go WAIT_EOC.
//  WAIT_EOC
//  - eoc = 1: go READ.
//  - Counter reaches TIMEOUT_CYC: timeout_err = 1 for 1 cycle; go NEXT; no data_valid.
//  READ
//  - oe = 1 for OE_CYC cycles.
//  - On the last of those cycles: data_out <= data_in, data_ch <= addr, data_valid = 1.
//  - Next cycle: oe = 0; go NEXT.
//  NEXT
//  - ptr <= addr + 1 (mod NUM_CH).
//  - If enable && mask != 0: addr <= next enabled channel from ptr (wrap); go SETUP.
//  - Else: go IDLE.
//  Channel selection:
//  - A single enabled channel is reconverted back-to-back.
//  - ch_mask and enable are sampled only in IDLE/NEXT; changes mid-conversion do not affect the current conversion.
//  Latency, START rise to data_valid: ALE_CYC + EOC_GUARD + t_eoc + OE_CYC cycles, t_eoc = cycles eoc is low.
//  Counters are $clog2-sized, saturating, and cleared on every state entry.
//  - The TIMEOUT counter must not wrap.
//  eoc already high on WAIT_EOC entry: take READ immediately (counter = 0).
// STRUCTURE
//  adc0808_defs.vh: state localparams, ADC_DATA_W = 8, ADC_ADDR_W = 3.
//  Sub-module adc_ch_picker (combinational):
//  - Inputs: mask, start ptr.
//  - Outputs: next enabled channel index, any_en flag.
//  - Search is round-robin with wrap.
//  - Used in IDLE and NEXT.
// TESTING
//  T1: mask = 8'h01, ADC model eoc 64 cycles -> ale/start 2-cycle pulses; addr = 0 always; data_valid every conversion with data_ch = 0 and data_out = model value.
//  T2: mask = 8'hA5 -> addr sequence 0,2,5,7,0,...; each data_valid carries the matching data_ch/value (model returns 8'h10 + ch).
//  T3: eoc stuck low -> timeout_err after GUARD + 1024 cycles; no data_valid; addr advances to next enabled channel.
//  T4: enable dropped mid-WAIT_EOC on ch 3 -> ch 3 sample still delivered; then IDLE, busy = 0, no further start.
//  T5: reset asserted during READ -> next cycle all outputs 0 and no data_valid; scan restarts at ch 0 when enable = 1.
//  T6: mask = 0 with enable = 1 -> stays IDLE, ale/start/oe never toggle; mask -> 8'h40 starts a conversion on ch 6.

Source files
------------

// File: rtl/adc0808_scan_ctrl_pkg.sv
// Shared types and constants for the ADC0808 scan controller.
// Holds the FSM state encoding, bus widths and small elaboration helpers.
package adc0808_scan_ctrl_pkg;

    localparam int ADC_DATA_W = 8;
    localparam int ADC_ADDR_W = 3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETUP    = 3'd1,
        ST_PULSE    = 3'd2,
        ST_GUARD    = 3'd3,
        ST_WAIT_EOC = 3'd4,
        ST_READ     = 3'd5,
        ST_NEXT     = 3'd6
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [ADC_ADDR_W-1:0] wrap_inc(input logic [ADC_ADDR_W-1:0] ch,
                                                       input int num_ch);
        return (int'(ch) >= (num_ch - 1)) ? 3'd0 : (ch + 3'd1);
    endfunction

endpackage

// File: rtl/adc0808_scan_ctrl_ch_picker.sv
// Combinational round-robin channel picker: first enabled channel at or after ptr_i,
// wrapping modulo NUM_CH; any_en_o flags that at least one channel is enabled.
module adc0808_scan_ctrl_ch_picker
    import adc0808_scan_ctrl_pkg::*;
#(
    parameter int NUM_CH = 8
) (
    input  logic [ADC_DATA_W-1:0] mask_i,
    input  logic [ADC_ADDR_W-1:0] ptr_i,
    output logic [ADC_ADDR_W-1:0] ch_o,
    output logic                  any_en_o
);

    logic [3:0]            idx_s;
    logic                  hit_s;
    logic [ADC_ADDR_W-1:0] ch_s;
    logic                  any_s;

    // Scan from the farthest offset down so the nearest enabled channel wins.
    always_comb begin
        idx_s = 4'd0;
        hit_s = 1'b0;
        ch_s  = 3'd0;
        any_s = 1'b0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx_s = {1'b0, ptr_i} + 4'(k);
            idx_s = (idx_s >= 4'(NUM_CH)) ? (idx_s - 4'(NUM_CH)) : idx_s;
            hit_s = mask_i[idx_s[2:0]];
            ch_s  = hit_s ? idx_s[2:0] : ch_s;
            any_s = any_s | hit_s;
        end
    end

    assign ch_o     = ch_s;
    assign any_en_o = any_s;

endmodule

// File: rtl/adc0808_scan_ctrl.sv
// ADC0808 scan controller: round-robins over masked channels, sequences ALE/START,
// waits on EOC with a timeout, reads via OE and emits tagged one-cycle samples.
module adc0808_scan_ctrl
    import adc0808_scan_ctrl_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int ALE_CYC     = 2,
    parameter int EOC_GUARD   = 10,
    parameter int OE_CYC      = 2,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic                  enable_i,
    input  logic [ADC_DATA_W-1:0] ch_mask_i,
    input  logic                  eoc_i,
    input  logic [ADC_DATA_W-1:0] data_in_i,
    output logic [ADC_ADDR_W-1:0] addr_o,
    output logic                  ale_o,
    output logic                  start_o,
    output logic                  oe_o,
    output logic [ADC_DATA_W-1:0] data_out_o,
    output logic [ADC_ADDR_W-1:0] data_ch_o,
    output logic                  data_valid_o,
    output logic                  timeout_err_o,
    output logic                  busy_o
);

    localparam int CNT_MAX    = max_int(max_int(ALE_CYC, EOC_GUARD), max_int(OE_CYC, TIMEOUT_CYC));
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int GUARD_LAST = (EOC_GUARD > 0) ? (EOC_GUARD - 1) : 0;
    localparam logic [ADC_DATA_W-1:0] MASK_LIM = ADC_DATA_W'((1 << NUM_CH) - 1);

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc_s;
    logic [ADC_ADDR_W-1:0]   addr_q, addr_d;
    logic [ADC_ADDR_W-1:0]   ptr_q, ptr_d;
    logic [ADC_DATA_W-1:0]   data_out_q, data_out_d;
    logic [ADC_ADDR_W-1:0]   data_ch_q, data_ch_d;
    logic                    valid_q, valid_d;
    logic                    tout_q, tout_d;
    logic                    ale_q, oe_q, busy_q;

    logic [ADC_DATA_W-1:0]   eff_mask_s;
    logic [ADC_ADDR_W-1:0]   nxt_ptr_s, pick_from_s, pick_ch_s;
    logic                    any_en_s;

    assign eff_mask_s  = ch_mask_i & MASK_LIM;
    assign nxt_ptr_s   = wrap_inc(addr_q, NUM_CH);
    assign pick_from_s = (state_q == ST_NEXT) ? nxt_ptr_s : ptr_q;
    assign cnt_inc_s   = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : (cnt_q + CNT_W'(1));

    adc0808_scan_ctrl_ch_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .mask_i   (eff_mask_s),
        .ptr_i    (pick_from_s),
        .ch_o     (pick_ch_s),
        .any_en_o (any_en_s)
    );

    // Next-state, channel sequencing and sample capture.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        ptr_d      = ptr_q;
        data_out_d = data_out_q;
        data_ch_d  = data_ch_q;
        valid_d    = 1'b0;
        tout_d     = 1'b0;
        cnt_d      = cnt_inc_s;
        case (state_q)
            ST_IDLE: begin
                if (enable_i && any_en_s) begin
                    addr_d  = pick_ch_s;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_d = ST_PULSE;
            end
            ST_PULSE: begin
                if (cnt_q >= CNT_W'(ALE_CYC - 1)) begin
                    state_d = ST_GUARD;
                end else begin
                    state_d = ST_PULSE;
                end
            end
            ST_GUARD: begin
                if (cnt_q >= CNT_W'(GUARD_LAST)) begin
                    state_d = ST_WAIT_EOC;
                end else begin
                    state_d = ST_GUARD;
                end
            end
            ST_WAIT_EOC: begin
                if (eoc_i) begin
                    state_d = ST_READ;
                end else if (cnt_q >= CNT_W'(TIMEOUT_CYC - 1)) begin
                    tout_d  = 1'b1;
                    state_d = ST_NEXT;
                end else begin
                    state_d = ST_WAIT_EOC;
                end
            end
            ST_READ: begin
                if (cnt_q >= CNT_W'(OE_CYC - 1)) begin
                    data_out_d = data_in_i;
                    data_ch_d  = addr_q;
                    valid_d    = 1'b1;
                    state_d    = ST_NEXT;
                end else begin
                    state_d = ST_READ;
                end
            end
            ST_NEXT: begin
                ptr_d = nxt_ptr_s;
                if (enable_i && any_en_s) begin
                    addr_d  = pick_ch_s;
                    state_d = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Every state entry restarts its cycle counter from zero.
        if (state_d != state_q) begin
            cnt_d = {CNT_W{1'b0}};
        end else begin
            cnt_d = cnt_d;
        end
    end

    // State, datapath and pin registers; pins are decoded from the next state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CNT_W{1'b0}};
            addr_q     <= 3'd0;
            ptr_q      <= 3'd0;
            data_out_q <= 8'd0;
            data_ch_q  <= 3'd0;
            valid_q    <= 1'b0;
            tout_q     <= 1'b0;
            ale_q      <= 1'b0;
            oe_q       <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            ptr_q      <= ptr_d;
            data_out_q <= data_out_d;
            data_ch_q  <= data_ch_d;
            valid_q    <= valid_d;
            tout_q     <= tout_d;
            ale_q      <= (state_d == ST_PULSE);
            oe_q       <= (state_d == ST_READ);
            busy_q     <= (state_d != ST_IDLE);
        end
    end

    assign addr_o        = addr_q;
    assign ale_o         = ale_q;
    assign start_o       = ale_q;
    assign oe_o          = oe_q;
    assign data_out_o    = data_out_q;
    assign data_ch_o     = data_ch_q;
    assign data_valid_o  = valid_q;
    assign timeout_err_o = tout_q;
    assign busy_o        = busy_q;

endmodule
